wb_operand_checker: RTL
=======================

WB_OPERAND_CHECKER -- requirements
Module: wb_operand_checker

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of snooped operand channels (1..8).
REQ-002 SHALL have parameter BASE_ADR, default 32'h3000_0000: channel k address = BASE_ADR + 4*k.
REQ-003 SHALL have parameter CHECK_DLY, default 2: cycles from write acceptance to compare (1..15).
REQ-004 SHALL have parameter CNT_W, default 16: pass/fail counter width.
REQ-005 SHALL have ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  asynchronous, active-high reset.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  snooped bus qualifiers.
- wbs_ack_i  in  1  snooped slave ack.
- wbs_adr_i  in  32  snooped address.
- wbs_dat_i  in  32  snooped write data.
- chan_en_i  in  NUM_CH  per-channel check enable.
- dut_val_i  in  32*NUM_CH  DUT register values; channel k = bits [32k+31:32k].
- test_start_i, test_end_i  in  1 each  single-cycle test markers.
- busy_o  out  1  test in progress.
- mismatch_o  out  1  one-cycle pulse per failed compare.
- mm_ch_o  out  3  channel of last mismatch.
- mm_exp_o, mm_act_o  out  32 each  bus data / DUT value of last mismatch.
- pass_cnt_o, fail_cnt_o  out  CNT_W each  test outcome counters.

Function
REQ-006 A hit SHALL be cyc&stb&we&ack with wbs_adr_i equal to a channel address whose chan_en_i bit is 1; other addresses ignored.
REQ-007 On a hit the channel SHALL capture wbs_dat_i and load its delay counter with CHECK_DLY; at counter zero it SHALL compare the capture with its dut_val_i slice.
REQ-008 Channels SHALL count independently; several may be pending at once.
REQ-009 A re-hit on a pending channel SHALL recapture data and restart its counter; only the newest write is compared.
REQ-010 Equal compare SHALL set the channel seen bit; unequal SHALL set seen and error bits, pulse mismatch_o one cycle after compare, update mm_ch_o/mm_exp_o/mm_act_o.
REQ-011 FSM states IDLE, ARMED, DRAIN: IDLE->ARMED on test_start_i (clears seen/error/pending); ARMED->DRAIN on test_end_i; DRAIN->IDLE when no channel pending.
REQ-012 On DRAIN exit: fail_cnt_o +1 if any error bit or any enabled channel unseen, else pass_cnt_o +1.
REQ-013 Hits in IDLE SHALL be ignored; hits in DRAIN SHALL still be checked.
REQ-014 test_start_i in ARMED/DRAIN SHALL abort the current test with fail_cnt_o +1 and re-arm.
REQ-015 Simultaneous test_start_i and test_end_i in IDLE: start wins, end ignored.
REQ-016 Counters SHALL saturate at all-ones.
REQ-017 busy_o SHALL be 1 in ARMED and DRAIN.

Reset
REQ-018 wb_rst_i SHALL asynchronously force IDLE, clear counters, pending/seen/error masks, and all outputs to 0; reset mid-test discards the test uncounted.

Configuration
REQ-019 With WB_CHK_LOG_EN defined, a 4-entry mismatch FIFO {ch,exp,act} with ports log_pop_i, log_vld_o, log_ch_o, log_exp_o, log_act_o SHALL exist; when full, new records drop and a sticky log_ovf_o sets until reset.
REQ-020 Without WB_CHK_LOG_EN, those ports and storage SHALL be absent; only last-mismatch registers remain.

Structure
REQ-021 Package wb_chk_pkg SHALL hold the FSM state enum, the mismatch record type and the channel-offset constant 4.
REQ-022 Per-channel capture/delay/compare SHALL be sub-module wb_chk_chan, instantiated NUM_CH times.

Verification
REQ-023 start; write 0x3F80_0000 to 0x3000_0000, DUT slice equal after 2 cycles; all 4 channels likewise; end -> pass_cnt_o=1, no mismatch_o.
REQ-024 Write 0x4000_0000 to 0x3000_0004, DUT slice 0x4040_0000 -> mismatch_o pulse, mm_ch_o=1, mm_exp_o=0x4000_0000, mm_act_o=0x4040_0000; end -> fail_cnt_o=1.
REQ-025 chan_en_i=4'b0011, only channels 0,1 written correctly -> pass; chan_en_i=4'b1111 same traffic -> fail (unseen).
REQ-026 Write channel 2 twice one cycle apart, first mismatching, second matching -> no mismatch_o.
REQ-027 test_end_i one cycle after last hit -> DRAIN holds busy_o until compare, then counts correctly.
REQ-028 wb_rst_i asserted while ARMED with pending channel -> outputs 0 immediately, counters 0; with WB_CHK_LOG_EN, 5 mismatches -> 4 logged, log_ovf_o=1.

Source files
------------

// File: rtl/wb_chk_pkg.sv
// wb_chk_pkg: shared FSM state, mismatch record and address stride for wb_operand_checker.
package wb_chk_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_DRAIN} state_e;
    typedef struct packed {
        logic [2:0]  ch;
        logic [31:0] exp;
        logic [31:0] act;
    } mm_rec_t;
    localparam int CH_OFS = 4;
endpackage

// File: rtl/wb_chk_chan.sv
// wb_chk_chan: one snooped channel; captures a write, waits CHECK_DLY cycles, then compares.
module wb_chk_chan #(
    parameter int CHECK_DLY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        hit,
    input  logic [31:0] wdat_i,
    input  logic [31:0] dut_val_i,
    output logic        pending_o,
    output logic        cmp_vld_o,
    output logic        cmp_ok_o,
    output logic [31:0] cap_o
);
    logic        pending_q, pending_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] cap_q, cap_d;
    always_comb begin
        cmp_vld_o = pending_q & (cnt_q == '0) & ~hit & ~clr;
        pending_d = clr ? 1'b0 : hit ? 1'b1 : cmp_vld_o ? 1'b0 : pending_q;
        cnt_d     = hit ? 4'(CHECK_DLY) : (pending_q && cnt_q != '0) ? cnt_q - 4'd1 : cnt_q;
        cap_d     = hit ? wdat_i : cap_q;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            pending_q <= 1'b0;
            cnt_q     <= '0;
            cap_q     <= '0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            cap_q     <= cap_d;
        end
    assign pending_o = pending_q;
    assign cmp_ok_o  = cap_q == dut_val_i;
    assign cap_o     = cap_q;
endmodule

// File: rtl/wb_operand_checker.sv
// wb_operand_checker: snoops Wishbone writes, checks DUT registers after a delay, counts test outcomes.
// Optional mismatch log FIFO enabled by defining WB_CHK_LOG_EN.
module wb_operand_checker
    import wb_chk_pkg::*;
#(
    parameter int          NUM_CH    = 4,
    parameter logic [31:0] BASE_ADR  = 32'h3000_0000,
    parameter int          CHECK_DLY = 2,
    parameter int          CNT_W     = 16
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 wbs_cyc_i,
    input  logic                 wbs_stb_i,
    input  logic                 wbs_we_i,
    input  logic                 wbs_ack_i,
    input  logic [31:0]          wbs_adr_i,
    input  logic [31:0]          wbs_dat_i,
    input  logic [NUM_CH-1:0]    chan_en_i,
    input  logic [32*NUM_CH-1:0] dut_val_i,
    input  logic                 test_start_i,
    input  logic                 test_end_i,
`ifdef WB_CHK_LOG_EN
    input  logic                 log_pop_i,
    output logic                 log_vld_o,
    output logic [2:0]           log_ch_o,
    output logic [31:0]          log_exp_o,
    output logic [31:0]          log_act_o,
    output logic                 log_ovf_o,
`endif
    output logic                 busy_o,
    output logic                 mismatch_o,
    output logic [2:0]           mm_ch_o,
    output logic [31:0]          mm_exp_o,
    output logic [31:0]          mm_act_o,
    output logic [CNT_W-1:0]     pass_cnt_o,
    output logic [CNT_W-1:0]     fail_cnt_o
);
    state_e             state_q, state_d;
    logic               bus_wr, abort, done, fail, rec_vld;
    logic [NUM_CH-1:0]  hit, pending, cmp_vld, cmp_ok;
    logic [NUM_CH-1:0]  seen_q, seen_d, err_q, err_d;
    logic [31:0]        cap [NUM_CH];
    mm_rec_t            rec, mm_q, mm_d;
    logic               mismatch_q, mismatch_d;
    logic [CNT_W-1:0]   pass_q, pass_d, fail_q, fail_d;

    // A start in the same cycle as a write wins: the write belongs to the aborted test.
    assign bus_wr = wbs_cyc_i & wbs_stb_i & wbs_we_i & wbs_ack_i & (state_q != ST_IDLE) & ~test_start_i;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign hit[k] = bus_wr & chan_en_i[k] & (wbs_adr_i == BASE_ADR + 32'(CH_OFS * k));
        wb_chk_chan #(.CHECK_DLY(CHECK_DLY)) u_chan (
            .clk       (wb_clk_i),
            .rst       (wb_rst_i),
            .clr       (test_start_i),
            .hit       (hit[k]),
            .wdat_i    (wbs_dat_i),
            .dut_val_i (dut_val_i[32*k +: 32]),
            .pending_o (pending[k]),
            .cmp_vld_o (cmp_vld[k]),
            .cmp_ok_o  (cmp_ok[k]),
            .cap_o     (cap[k])
        );
    end

    always_comb begin
        state_d = test_start_i ? ST_ARMED :
                  (state_q == ST_ARMED && test_end_i) ? ST_DRAIN :
                  (state_q == ST_DRAIN && pending == '0 && hit == '0) ? ST_IDLE : state_q;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i)
        if (wb_rst_i) state_q <= ST_IDLE;
        else          state_q <= state_d;

    always_comb begin
        busy_o = state_q != ST_IDLE;
    end

    // Simultaneous failures report the lowest channel.
    always_comb begin
        rec_vld = 1'b0;
        rec     = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (cmp_vld[i] && !cmp_ok[i]) begin
                rec_vld = 1'b1;
                rec     = {3'(i), cap[i], dut_val_i[32*i +: 32]};
            end
    end

    always_comb begin
        abort      = test_start_i & (state_q != ST_IDLE);
        done       = (state_q == ST_DRAIN) & (state_d == ST_IDLE);
        fail       = (err_q != '0) | ((chan_en_i & ~seen_q) != '0);
        seen_d     = test_start_i ? '0 : seen_q | cmp_vld;
        err_d      = test_start_i ? '0 : err_q | (cmp_vld & ~cmp_ok);
        mismatch_d = rec_vld;
        mm_d       = rec_vld ? rec : mm_q;
        pass_d     = (done && !fail && !(&pass_q)) ? pass_q + CNT_W'(1) : pass_q;
        fail_d     = ((abort || (done && fail)) && !(&fail_q)) ? fail_q + CNT_W'(1) : fail_q;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i)
        if (wb_rst_i) begin
            seen_q     <= '0;
            err_q      <= '0;
            mismatch_q <= 1'b0;
            mm_q       <= '0;
            pass_q     <= '0;
            fail_q     <= '0;
        end else begin
            seen_q     <= seen_d;
            err_q      <= err_d;
            mismatch_q <= mismatch_d;
            mm_q       <= mm_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
        end

    assign mismatch_o = mismatch_q;
    assign mm_ch_o    = mm_q.ch;
    assign mm_exp_o   = mm_q.exp;
    assign mm_act_o   = mm_q.act;
    assign pass_cnt_o = pass_q;
    assign fail_cnt_o = fail_q;

`ifdef WB_CHK_LOG_EN
    mm_rec_t    log_mem_q [4], log_mem_d [4];
    logic [1:0] wr_q, wr_d, rd_q, rd_d;
    logic [2:0] lcnt_q, lcnt_d;
    logic       ovf_q, ovf_d, push, pop;

    // A full log drops new records even when a pop happens in the same cycle.
    always_comb begin
        pop       = log_pop_i & (lcnt_q != '0);
        push      = rec_vld & (lcnt_q != 3'd4);
        wr_d      = wr_q + 2'(push);
        rd_d      = rd_q + 2'(pop);
        lcnt_d    = lcnt_q + 3'(push) - 3'(pop);
        ovf_d     = ovf_q | (rec_vld & (lcnt_q == 3'd4));
        log_mem_d = log_mem_q;
        if (push) log_mem_d[wr_q] = rec;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i)
        if (wb_rst_i) begin
            for (int i = 0; i < 4; i++) log_mem_q[i] <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            lcnt_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            log_mem_q <= log_mem_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            lcnt_q    <= lcnt_d;
            ovf_q     <= ovf_d;
        end

    assign log_vld_o = lcnt_q != '0;
    assign log_ch_o  = log_mem_q[rd_q].ch;
    assign log_exp_o = log_mem_q[rd_q].exp;
    assign log_act_o = log_mem_q[rd_q].act;
    assign log_ovf_o = ovf_q;
`endif
endmodule
